// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg
//   Shared definitions for the queue blocks built on the flushable sync FIFO.
//   - addr_w_f   : address width (log2 of depth) used to size pointers/count
//   - fifo_err_t : sticky error flag pair, reused by other queue blocks
package sync_fifo_pkg;

  function automatic int addr_w_f(input int depth);
    return $clog2(depth);
  endfunction

  typedef struct packed {
    logic overflow;
    logic underflow;
  } fifo_err_t;

endpackage

// File: rtl/sync_fifo_flush_if.sv
// sync_fifo_flush_if
//   Request/status bundle between a queue producer/consumer and sync_fifo_flush.
//   Handshake: enqueue/dequeue are requests sampled at posedge clk. A request
//   is accepted only when the FIFO state before the edge allows it
//   (enqueue needs ~is_full, dequeue needs ~is_empty); there is no ready
//   back-pressure beyond those two flags, and a refused request raises the
//   matching sticky error flag. rdata updates one cycle after an accepted
//   dequeue and otherwise holds.
//   master : drives flush, enqueue, wdata, dequeue, err_clr
//   slave  : the FIFO; drives rdata, flags, count, overflow, underflow
interface sync_fifo_flush_if #(
  parameter int DATA_WIDTH  = 64,
  parameter int QUEUE_DEPTH = 16
);
  localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;

  logic                  flush;
  logic                  enqueue;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  dequeue;
  logic                  err_clr;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  is_full;
  logic                  is_empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [CNT_W-1:0]      count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output flush, enqueue, wdata, dequeue, err_clr,
    input  rdata, is_full, is_empty, almost_full, almost_empty, count,
           overflow, underflow
  );

  modport slave (
    input  flush, enqueue, wdata, dequeue, err_clr,
    output rdata, is_full, is_empty, almost_full, almost_empty, count,
           overflow, underflow
  );

endinterface

// File: rtl/fifo_ram_2p.sv
// fifo_ram_2p
//   DATA_WIDTH x DEPTH register array, one write port and one synchronous
//   read port with read enable. No reset: contents and read register are
//   undefined until written.
//   clk      : clock
//   i_we     : write enable
//   i_waddr  : write address
//   i_wdata  : write data
//   i_re     : read enable; o_rdata loads mem[i_raddr] at the edge
//   i_raddr  : read address
//   o_rdata  : registered read data, holds when i_re is low
module fifo_ram_2p #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = 4
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [ADDR_W-1:0]     i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [ADDR_W-1:0]     i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      r_q <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/sync_fifo_flush.sv
// sync_fifo_flush
//   Single-clock FIFO for pipeline queues with synchronous flush, occupancy
//   count, programmable almost-full/almost-empty and sticky error flags.
//   Read data is registered and appears one cycle after an accepted dequeue.
//   clk  : clock, all logic on posedge
//   rst  : synchronous reset, active-low (outranks flush)
//   bus  : slave side of sync_fifo_flush_if
//          in : flush, enqueue, wdata, dequeue, err_clr
//          out: rdata, is_full, is_empty, almost_full, almost_empty, count,
//               overflow, underflow
module sync_fifo_flush
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int QUEUE_DEPTH = 16,
  parameter int AF_THRESH   = 14,
  parameter int AE_THRESH   = 2
) (
  input  logic                clk,
  input  logic                rst,
  sync_fifo_flush_if.slave    bus
);

  localparam int ADDR_W = addr_w_f(QUEUE_DEPTH);
  localparam int PTR_W  = ADDR_W + 1;
  localparam int CNT_W  = ADDR_W + 1;
  localparam logic [CNT_W-1:0] AF_LVL = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] AE_LVL = CNT_W'(AE_THRESH);

  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic                  r_rdata_zero;
  fifo_err_t             r_err;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic                  w_ovf_evt;
  logic                  w_udf_evt;
  logic [DATA_WIDTH-1:0] w_ram_q;

  // Wrap bit distinguishes full from empty when the address bits match.
  assign w_full  = (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]) &&
                   (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]);
  assign w_empty = (r_wr_ptr == r_rd_ptr);

  // Flush (and reset) swallow requests entirely: no access, no error event.
  assign w_wr_acc  = rst & ~bus.flush & bus.enqueue & ~w_full;
  assign w_rd_acc  = rst & ~bus.flush & bus.dequeue & ~w_empty;
  assign w_ovf_evt = rst & ~bus.flush & bus.enqueue & w_full;
  assign w_udf_evt = rst & ~bus.flush & bus.dequeue & w_empty;

  fifo_ram_2p #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (QUEUE_DEPTH),
    .ADDR_W     (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_wr_acc),
    .i_waddr (r_wr_ptr[ADDR_W-1:0]),
    .i_wdata (bus.wdata),
    .i_re    (w_rd_acc),
    .i_raddr (r_rd_ptr[ADDR_W-1:0]),
    .o_rdata (w_ram_q)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_rdata_zero <= 1'b1;
      r_err        <= '0;
    end else begin
      if (bus.flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
        case ({w_wr_acc, w_rd_acc})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
      // The RAM read register has no reset; this flag masks it to zero
      // until the first accepted dequeue after reset.
      if (w_rd_acc) r_rdata_zero <= 1'b0;
      // A new event in the same cycle as err_clr keeps the flag set.
      r_err.overflow  <= w_ovf_evt | (r_err.overflow  & ~bus.err_clr);
      r_err.underflow <= w_udf_evt | (r_err.underflow & ~bus.err_clr);
    end
  end

  assign bus.rdata        = r_rdata_zero ? '0 : w_ram_q;
  assign bus.is_full      = w_full;
  assign bus.is_empty     = w_empty;
  assign bus.almost_full  = (r_count >= AF_LVL);
  assign bus.almost_empty = (r_count <= AE_LVL);
  assign bus.count        = r_count;
  assign bus.overflow     = r_err.overflow;
  assign bus.underflow    = r_err.underflow;

endmodule

// File: tb/tb_sync_fifo_flush.sv
module tb_sync_fifo_flush;

  localparam int DW    = 64;
  localparam int DEPTH = 16;
  localparam int AF    = 14;
  localparam int AE    = 2;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sync_fifo_flush_if #(.DATA_WIDTH(DW), .QUEUE_DEPTH(DEPTH)) bus ();

  sync_fifo_flush #(
    .DATA_WIDTH  (DW),
    .QUEUE_DEPTH (DEPTH),
    .AF_THRESH   (AF),
    .AE_THRESH   (AE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- scoreboard / reference model ----------------
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] m_rdata;
  logic          m_ovf;
  logic          m_udf;

  int n_total;
  int n_bad;

  task automatic check(input string tag, input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  task automatic check_all();
    int sz;
    sz = exp_q.size();
    check("count",        DW'(bus.count),      DW'(sz));
    check("is_full",      DW'(bus.is_full),    DW'(sz == DEPTH));
    check("is_empty",     DW'(bus.is_empty),   DW'(sz == 0));
    check("almost_full",  DW'(bus.almost_full), DW'(sz >= AF));
    check("almost_empty", DW'(bus.almost_empty), DW'(sz <= AE));
    check("rdata",        bus.rdata,           m_rdata);
    check("overflow",     DW'(bus.overflow),   DW'(m_ovf));
    check("underflow",    DW'(bus.underflow),  DW'(m_udf));
  endtask

  // ---------------- driver tasks ----------------
  // One clock of stimulus; model is advanced from its pre-edge state.
  task automatic step(input logic fl, input logic en, input logic [DW-1:0] wd,
                      input logic de, input logic ec);
    logic full, empty, ovf_e, udf_e;
    bus.flush   = fl;
    bus.enqueue = en;
    bus.wdata   = wd;
    bus.dequeue = de;
    bus.err_clr = ec;
    ovf_e = 1'b0;
    udf_e = 1'b0;
    if (fl) begin
      exp_q.delete();
    end else begin
      full  = (exp_q.size() == DEPTH);
      empty = (exp_q.size() == 0);
      ovf_e = en && full;
      udf_e = de && empty;
      if (de && !empty) m_rdata = exp_q.pop_front();
      if (en && !full)  exp_q.push_back(wd);
    end
    m_ovf = ovf_e | (m_ovf & ~ec);
    m_udf = udf_e | (m_udf & ~ec);
    @(posedge clk);
    #1;
    check_all();
  endtask

  // Reset held for `cycles` edges; requests (including flush) may be active.
  task automatic do_reset(input int cycles, input logic fl, input logic en,
                          input logic de);
    rst         = 1'b0;
    bus.flush   = fl;
    bus.enqueue = en;
    bus.wdata   = 64'hBAD0_BAD0_BAD0_BAD0;
    bus.dequeue = de;
    bus.err_clr = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    exp_q.delete();
    m_rdata = '0;
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
    check_all();
    rst         = 1'b1;
    bus.flush   = 1'b0;
    bus.enqueue = 1'b0;
    bus.dequeue = 1'b0;
  endtask

  function automatic logic [DW-1:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    n_total = 0;
    n_bad   = 0;
    m_rdata = '0;
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
    rst     = 1'b0;

    do_reset(2, 1'b0, 1'b0, 1'b0);

    // Fill 0x1..0x10, then drain.
    for (int i = 1; i <= DEPTH; i++) step(1'b0, 1'b1, DW'(i), 1'b0, 1'b0);
    for (int i = 1; i <= DEPTH; i++) step(1'b0, 1'b0, '0, 1'b1, 1'b0);

    // Overflow: at full, enqueue with dequeue; the enqueue is dropped.
    for (int i = 1; i <= DEPTH; i++) step(1'b0, 1'b1, DW'(i + 32), 1'b0, 1'b0);
    step(1'b0, 1'b1, 64'hDEAD, 1'b1, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    // err_clr together with a fresh overflow keeps the flag set.
    step(1'b0, 1'b1, 64'h77, 1'b0, 1'b0);
    step(1'b0, 1'b1, 64'hDEAD, 1'b0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    repeat (DEPTH) step(1'b0, 1'b0, '0, 1'b1, 1'b0);

    // Underflow: empty, enqueue + dequeue together.
    step(1'b0, 1'b1, 64'hA5, 1'b1, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);

    // Flush at count=5 together with enqueue.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, rnd64(), 1'b0, 1'b0);
    step(1'b1, 1'b1, 64'h1234, 1'b1, 1'b0);
    step(1'b0, 1'b1, 64'h7, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    // Flush while empty with dequeue must not raise underflow.
    step(1'b1, 1'b0, '0, 1'b1, 1'b0);

    // Wrap: hold count at 8 with simultaneous enqueue/dequeue.
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, rnd64(), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) step(1'b0, 1'b1, rnd64(), 1'b1, 1'b0);

    // Random traffic, with one reset in the middle (flush also asserted).
    for (int i = 0; i < 600; i++) begin
      if (i == 300) begin
        do_reset(1, 1'b1, 1'b1, 1'b1);
      end else begin
        step(($urandom_range(0, 40) == 0),
             ($urandom_range(0, 99) < (i < 150 ? 70 : 45)),
             rnd64(),
             ($urandom_range(0, 99) < (i < 150 ? 40 : 55)),
             ($urandom_range(0, 15) == 0));
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
